// File: rtl/rca_ora.sv
// Output response analyzer for the ripple-carry adder self-test path.
// Recomputes a+b+cin on chip, aligns it to the adder latency, and scores an 8-pattern session.
module rca_ora #(
  parameter int WIDTH = 5,
  parameter int LAT   = 0
) (
  input  logic             clk,
  input  logic             init,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_1,
  input  logic [WIDTH-1:0] s,
  input  logic             c_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [3:0]       err_cnt,
  output logic [2:0]       first_fail,
  output logic [WIDTH:0]   syndrome
);

  typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;

  localparam logic [1:0] FILL_LAST = 2'(LAT - 1);

  state_t         state, nxt;
  logic [1:0]     fill_cnt;
  logic [2:0]     idx;
  logic [WIDTH:0] exp_now, exp_al, err;
  logic           mis, start_ok;

  assign exp_now = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c_1};

  // Delay line shifts unconditionally so it is already primed when FILL ends.
  generate
    if (LAT > 0) begin : g_dly
      logic [LAT-1:0][WIDTH:0] dl_q;
      always_ff @(posedge clk) begin
        if (!init) begin
          dl_q <= '0;
        end else begin
          dl_q[0] <= exp_now;
          for (int i = 1; i < LAT; i++) dl_q[i] <= dl_q[i-1];
        end
      end
      assign exp_al = dl_q[LAT-1];
    end else begin : g_nodly
      assign exp_al = exp_now;
    end
  endgenerate

  assign err      = {c_out, s} ^ exp_al;
  assign mis      = |err;
  assign start_ok = start && (state == IDLE || state == DONE);

  always_ff @(posedge clk) begin
    if (!init) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE: if (start) nxt = (LAT == 0) ? RUN : FILL;
      FILL:       if (fill_cnt == FILL_LAST) nxt = RUN;
      RUN:        if (idx == 3'd7) nxt = DONE;
      default:    nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!init) begin
      fill_cnt   <= '0;
      idx        <= '0;
      err_cnt    <= '0;
      first_fail <= '0;
      syndrome   <= '0;
    end else if (start_ok) begin
      fill_cnt   <= '0;
      idx        <= '0;
      err_cnt    <= '0;
      first_fail <= '0;
      syndrome   <= '0;
    end else if (state == FILL) begin
      fill_cnt <= fill_cnt + 2'd1;
    end else if (state == RUN) begin
      idx <= idx + 3'd1;
      if (mis) begin
        err_cnt  <= err_cnt + 4'd1;
        syndrome <= syndrome | err;
        if (err_cnt == 4'd0) first_fail <= idx;
      end
    end
  end

  // Pure decodes of registered state, so no input reaches an output combinationally.
  assign busy = (state == FILL) || (state == RUN);
  assign done = (state == DONE);
  assign pass = done && (err_cnt == 4'd0);

endmodule

// File: tb/tb_rca_ora.sv
// Directed bench for rca_ora: one LAT=0 instance and one LAT=2 instance fed by
// a two-stage registered adder model (or an unaligned combinational one).
module tb_rca_ora;
  localparam int W = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         init, start0, start2, c_1, co0, unaligned, sel;
  logic [W-1:0] a, b, s0;
  logic [W:0]   gold, r1, r2, resp2;

  logic         busy0, done0, pass0, busy2, done2, pass2;
  logic [3:0]   ec0, ec2;
  logic [2:0]   ff0, ff2;
  logic [W:0]   syn0, syn2;

  logic         o_busy, o_done, o_pass;
  logic [3:0]   o_ec;
  logic [2:0]   o_ff;
  logic [W:0]   o_syn;

  int checks = 0;
  int errors = 0;

  assign gold  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c_1};
  always @(posedge clk) begin
    r1 <= gold;
    r2 <= r1;
  end
  assign resp2 = unaligned ? gold : r2;

  assign o_busy = sel ? busy2 : busy0;
  assign o_done = sel ? done2 : done0;
  assign o_pass = sel ? pass2 : pass0;
  assign o_ec   = sel ? ec2   : ec0;
  assign o_ff   = sel ? ff2   : ff0;
  assign o_syn  = sel ? syn2  : syn0;

  rca_ora #(.WIDTH(W), .LAT(0)) u0 (
    .clk(clk), .init(init), .start(start0), .a(a), .b(b), .c_1(c_1),
    .s(s0), .c_out(co0), .busy(busy0), .done(done0), .pass(pass0),
    .err_cnt(ec0), .first_fail(ff0), .syndrome(syn0)
  );

  rca_ora #(.WIDTH(W), .LAT(2)) u2 (
    .clk(clk), .init(init), .start(start2), .a(a), .b(b), .c_1(c_1),
    .s(resp2[W-1:0]), .c_out(resp2[W]), .busy(busy2), .done(done2), .pass(pass2),
    .err_cnt(ec2), .first_fail(ff2), .syndrome(syn2)
  );

  // Generator pattern set; golden sums are 0,32,9,16,63,4,20,31.
  logic [W-1:0] pa [8];
  logic [W-1:0] pb [8];
  logic         pc [8];

  // Fault injected on the LAT=0 adder response.
  logic [W:0] fx, f0, f1;
  logic [7:0] fi;

  typedef struct {
    logic [W:0] xmask;
    logic [7:0] imask;
    logic [W:0] sa0;
    logic [W:0] sa1;
    int         pulse_at;
    logic [3:0] e_cnt;
    logic [2:0] e_ff;
    logic [W:0] e_syn;
    logic       e_pass;
  } vec_t;

  vec_t vt [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_pat(input int i);
    logic [W:0] r;
    if (i < 8) begin
      a = pa[i]; b = pb[i]; c_1 = pc[i];
    end else begin
      a = '0; b = '0; c_1 = 1'b0;
    end
    r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c_1};
    if (i < 8 && fi[i]) r = r ^ fx;
    r = (r & ~f0) | f1;
    {co0, s0} = r;
  endtask

  task automatic set_start(input logic v);
    if (sel) start2 = v;
    else     start0 = v;
  endtask

  task automatic run_session(input string tag, input int lat, input int pulse_at,
                             input logic [3:0] e_cnt, input logic [2:0] e_ff,
                             input logic [W:0] e_syn, input logic e_pass);
    logic bad;
    @(negedge clk);
    set_start(1'b1);
    drive_pat(0);
    @(posedge clk);
    @(negedge clk);
    set_start(1'b0);
    chk({tag, "_clear"}, {o_ec, o_ff, o_syn}, 0);
    bad = 1'b0;
    for (int t = 0; t < lat + 8; t++) begin
      if (!(o_busy && !o_done && !o_pass)) bad = 1'b1;
      drive_pat(t);
      set_start(t == pulse_at);
      @(posedge clk);
      @(negedge clk);
    end
    set_start(1'b0);
    chk({tag, "_busy_window"}, bad, 0);
    chk({tag, "_busy_done"}, {o_busy, o_done}, 2'b01);
    chk({tag, "_err_cnt"}, o_ec, e_cnt);
    chk({tag, "_first_fail"}, o_ff, e_ff);
    chk({tag, "_syndrome"}, o_syn, e_syn);
    chk({tag, "_pass"}, o_pass, e_pass);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_pass"}, o_pass, 0);
    chk({tag, "_err_cnt"}, o_ec, 0);
    chk({tag, "_first_fail"}, o_ff, 0);
    chk({tag, "_syndrome"}, o_syn, 0);
  endtask

  initial begin
    pa[0] = 5'd0;  pb[0] = 5'd0;  pc[0] = 1'b0;
    pa[1] = 5'd31; pb[1] = 5'd1;  pc[1] = 1'b0;
    pa[2] = 5'd5;  pb[2] = 5'd3;  pc[2] = 1'b1;
    pa[3] = 5'd10; pb[3] = 5'd6;  pc[3] = 1'b0;
    pa[4] = 5'd31; pb[4] = 5'd31; pc[4] = 1'b1;
    pa[5] = 5'd4;  pb[5] = 5'd0;  pc[5] = 1'b0;
    pa[6] = 5'd12; pb[6] = 5'd7;  pc[6] = 1'b1;
    pa[7] = 5'd21; pb[7] = 5'd10; pc[7] = 1'b0;

    //        xmask      imask        sa0        sa1     pulse cnt ff  syn        pass
    vt[0] = '{6'b000000, 8'h00,       6'b000000, 6'b000000, -1, 4'd0, 3'd0, 6'b000000, 1'b1};
    vt[1] = '{6'b100000, 8'b00001000, 6'b000000, 6'b000000,  3, 4'd1, 3'd3, 6'b100000, 1'b0};
    vt[2] = '{6'b000000, 8'h00,       6'b000100, 6'b000000, -1, 4'd4, 3'd4, 6'b000100, 1'b0};
    vt[3] = '{6'b000000, 8'h00,       6'b000000, 6'b010000, -1, 4'd4, 3'd0, 6'b010000, 1'b0};
    vt[4] = '{6'b000001, 8'hff,       6'b000000, 6'b000000, -1, 4'd8, 3'd0, 6'b000001, 1'b0};
    vt[5] = '{6'b000000, 8'h00,       6'b000000, 6'b000000, -1, 4'd0, 3'd0, 6'b000000, 1'b1};

    fx = '0; f0 = '0; f1 = '0; fi = '0;
    unaligned = 1'b0;
    sel = 1'b0;

    // Reset dominates a held start with random operands.
    init = 1'b0; start0 = 1'b1; start2 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      a = 5'($urandom); b = 5'($urandom); c_1 = 1'($urandom);
      s0 = 5'($urandom); co0 = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
    end
    sel = 1'b0; chk_zero("reset_lat0");
    sel = 1'b1; chk_zero("reset_lat2");
    init = 1'b1; start0 = 1'b0; start2 = 1'b0;
    @(negedge clk);

    // LAT=0 table, back-to-back sessions each restarted from DONE.
    sel = 1'b0;
    for (int v = 0; v < 6; v++) begin
      fx = vt[v].xmask; fi = vt[v].imask; f0 = vt[v].sa0; f1 = vt[v].sa1;
      run_session($sformatf("lat0_v%0d", v), 0, vt[v].pulse_at,
                  vt[v].e_cnt, vt[v].e_ff, vt[v].e_syn, vt[v].e_pass);
    end
    fx = '0; fi = '0; f0 = '0; f1 = '0;

    // LAT=2 with aligned registered adder, then with an unaligned combinational one.
    sel = 1'b1;
    unaligned = 1'b0;
    run_session("lat2_aligned", 2, -1, 4'd0, 3'd0, 6'b000000, 1'b1);
    unaligned = 1'b1;
    run_session("lat2_unaligned", 2, -1, 4'd8, 3'd0, 6'b111111, 1'b0);
    unaligned = 1'b0;

    // Abort at RUN index 5 with a carry fault on every pattern.
    sel = 1'b0;
    fx = 6'b100000; fi = 8'hff;
    @(negedge clk);
    start0 = 1'b1;
    drive_pat(0);
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    for (int t = 0; t < 5; t++) begin
      drive_pat(t);
      @(posedge clk);
      @(negedge clk);
    end
    chk("abort_pre_err_cnt", ec0, 4'd5);
    init = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_zero("abort");
    init = 1'b1;
    for (int t = 0; t < 10; t++) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk_zero("abort_idle");
    fx = '0; fi = '0;
    run_session("after_abort", 0, -1, 4'd0, 3'd0, 6'b000000, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
